// File: rtl/drone_plant.sv
// Shaft-and-payload model that answers the drone delivery controller.
// Tracks cage position, runs the timed payload release, and flags protocol violations.
module drone_plant #(
   parameter int TRAVEL_CYCLES = 8,
   parameter int DROP_CYCLES   = 3,
   parameter int POS_W         = 4,
   parameter int CNT_W         = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       motor,
   input  logic [1:0]       drop,
   output logic [1:0]       floor,
   output logic [1:0]       fs,
   output logic [POS_W-1:0] pos,
   output logic             fault,
   output logic [CNT_W-1:0] dcnt5,
   output logic [CNT_W-1:0] dcnt6
);

   localparam int TW = $clog2(DROP_CYCLES + 1);
   localparam logic [POS_W-1:0] TOP       = POS_W'(TRAVEL_CYCLES);
   localparam logic [TW-1:0]    DROP_DONE = TW'(DROP_CYCLES);

   typedef enum logic [1:0] {IDLE, DROPPING, WAIT_RELEASE} state_e;

   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             sel_q, sel_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [1:0]       fs_q, fs_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] dcnt5_q, dcnt5_d;
   logic [CNT_W-1:0] dcnt6_q, dcnt6_d;

   logic motorIdle, badDrop, legalDrop, viol, fire;

   assign floor = {pos_q == TOP, pos_q == '0};
   assign pos   = pos_q;
   assign fs    = fs_q;
   assign fault = fault_q;
   assign dcnt5 = dcnt5_q;
   assign dcnt6 = dcnt6_q;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      sel_d    = sel_q;
      pos_d    = pos_q;
      fs_d     = 2'b00;
      dcnt5_d  = dcnt5_q;
      dcnt6_d  = dcnt6_q;
      fire     = 1'b0;

      motorIdle = (motor == 2'b00);
      badDrop   = (drop == 2'b11) | (drop[0] & ~floor[0]) | (drop[1] & ~floor[1]);
      legalDrop = (drop != 2'b00) & ~badDrop;
      viol      = (motor == 2'b11) | badDrop;

      // A motor command in the same cycle as a valid drop request wins as a violation
      unique case (state_q)
         IDLE: begin
            if (legalDrop) begin
               if (motorIdle) begin
                  sel_d   = drop[1];
                  timer_d = TW'(1);
                  if (DROP_DONE == TW'(1)) fire = 1'b1;
                  else                     state_d = DROPPING;
               end else begin
                  viol = 1'b1;
               end
            end
         end
         DROPPING: begin
            if (!motorIdle) begin
               state_d = IDLE;
               timer_d = '0;
               viol    = 1'b1;
            end else if (!drop[sel_q]) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
               if (timer_d == DROP_DONE) fire = 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (drop == 2'b00) begin
               state_d = IDLE;
               timer_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (fire) begin
         state_d = WAIT_RELEASE;
         fs_d    = sel_d ? 2'b10 : 2'b01;
         if (sel_d) begin
            if (dcnt6_q != '1) dcnt6_d = dcnt6_q + CNT_W'(1);
         end else begin
            if (dcnt5_q != '1) dcnt5_d = dcnt5_q + CNT_W'(1);
         end
      end

      if (motor == 2'b01 && pos_q != TOP)      pos_d = pos_q + POS_W'(1);
      else if (motor == 2'b10 && pos_q != '0)  pos_d = pos_q - POS_W'(1);

      fault_d = fault_q | viol;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         sel_q   <= 1'b0;
         pos_q   <= '0;
         fs_q    <= 2'b00;
         fault_q <= 1'b0;
         dcnt5_q <= '0;
         dcnt6_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         sel_q   <= sel_d;
         pos_q   <= pos_d;
         fs_q    <= fs_d;
         fault_q <= fault_d;
         dcnt5_q <= dcnt5_d;
         dcnt6_q <= dcnt6_d;
      end
   end

endmodule

// File: tb/tb_drone_plant.sv
// Scoreboard bench for drone_plant: a behavioural plant model predicts every
// post-edge output, the prediction is queued and then compared against the DUT.
module tb_drone_plant;

   localparam int TC = 8;
   localparam int DC = 3;
   localparam int PW = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    motor = 2'b00;
   logic [1:0]    drop = 2'b00;
   logic [1:0]    floor, fs;
   logic [PW-1:0] pos;
   logic          fault;
   logic [CW-1:0] dcnt5, dcnt6;

   drone_plant #(.TRAVEL_CYCLES(TC), .DROP_CYCLES(DC), .POS_W(PW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .motor(motor), .drop(drop),
      .floor(floor), .fs(fs), .pos(pos), .fault(fault),
      .dcnt5(dcnt5), .dcnt6(dcnt6)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pos; int floor; int fs; int fault; int d5; int d6;
   } expect_t;

   expect_t sb[$];
   int checks = 0;
   int errors = 0;

   // Model state: 0 idle, 1 dropping, 2 waiting for release
   int mPos = 0, mState = 0, mTimer = 0, mSel = 0, mFault = 0, mD5 = 0, mD6 = 0, mFs = 0;

   task automatic checkOutput(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int floorOf(input int p);
      if (p == 0)  return 1;
      if (p == TC) return 2;
      return 0;
   endfunction

   task automatic modelStep(input bit r, input int m, input int d);
      bit at5, at6, bad, complete;
      if (!r) begin
         mPos = 0; mState = 0; mTimer = 0; mSel = 0; mFault = 0; mD5 = 0; mD6 = 0; mFs = 0;
         return;
      end
      at5 = (mPos == 0);
      at6 = (mPos == TC);
      bad = (m == 3) || (d == 3) || ((d == 1) && !at5) || ((d == 2) && !at6);
      complete = 0;
      mFs = 0;
      if (mState == 0) begin
         if (((d == 1) && at5) || ((d == 2) && at6)) begin
            if (m != 0) bad = 1;
            else begin
               mSel = (d == 2);
               mTimer = 1;
               mState = 1;
               if (mTimer == DC) complete = 1;
            end
         end
      end else if (mState == 1) begin
         if (m != 0) begin
            bad = 1; mState = 0;
         end else if (((d >> mSel) & 1) == 0) begin
            mState = 0;
         end else begin
            mTimer++;
            if (mTimer == DC) complete = 1;
         end
      end else if (d == 0) begin
         mState = 0;
      end
      if (complete) begin
         mState = 2;
         mFs = mSel ? 2 : 1;
         if (mSel) mD6 = (mD6 == 15) ? 15 : mD6 + 1;
         else      mD5 = (mD5 == 15) ? 15 : mD5 + 1;
      end
      if (m == 1 && mPos < TC) mPos++;
      else if (m == 2 && mPos > 0) mPos--;
      if (bad) mFault = 1;
   endtask

   task automatic applyStimulus(input bit r, input int m, input int d, input int n);
      expect_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         rst_n = r;
         motor = 2'(m);
         drop  = 2'(d);
         modelStep(r, m, d);
         e.pos = mPos; e.floor = floorOf(mPos); e.fs = mFs;
         e.fault = mFault; e.d5 = mD5; e.d6 = mD6;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            checkOutput("queueEmpty", 0, 1);
         end else begin
            e = sb.pop_front();
            checkOutput("pos", int'(pos), e.pos);
            checkOutput("floor", int'(floor), e.floor);
            checkOutput("fs", int'(fs), e.fs);
            checkOutput("fault", int'(fault), e.fault);
            checkOutput("dcnt5", int'(dcnt5), e.d5);
            checkOutput("dcnt6", int'(dcnt6), e.d6);
         end
      end
   endtask

   initial begin
      applyStimulus(0, 0, 0, 2);
      checkOutput("resetFloor", int'(floor), 1);

      // Travel up to floor 6 and push against the top stop
      applyStimulus(1, 1, 0, TC);
      checkOutput("topPos", int'(pos), TC);
      checkOutput("topFloor", int'(floor), 2);
      applyStimulus(1, 1, 0, 1);
      checkOutput("endStopFault", int'(fault), 0);

      // Drop at floor 6, long hold, release, repeat
      applyStimulus(1, 0, 2, 2);
      checkOutput("fsEarly", int'(fs), 0);
      applyStimulus(1, 0, 2, 1);
      checkOutput("fsPulse6", int'(fs), 2);
      applyStimulus(1, 0, 2, 5);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 0, 2, 3);
      applyStimulus(1, 0, 0, 1);
      checkOutput("dcnt6Two", int'(dcnt6), 2);

      // Back to floor 5, aborted drop
      applyStimulus(1, 2, 0, TC);
      applyStimulus(1, 0, 1, 2);
      applyStimulus(1, 0, 0, 2);
      checkOutput("abortNoCount", int'(dcnt5), 0);

      // Drop request between floors, then return
      applyStimulus(1, 1, 0, 4);
      applyStimulus(1, 0, 1, 1);
      checkOutput("midDropFault", int'(fault), 1);
      applyStimulus(1, 2, 0, 4);

      // Motor during drop, motor 11 from reset
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 1, 2);
      applyStimulus(1, 1, 1, 1);
      checkOutput("motorDuringDropPos", int'(pos), 1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 3, 0, 1);
      checkOutput("motor11Pos", int'(pos), 0);

      // Reset mid-travel and mid-drop
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 1, 0, 5);
      applyStimulus(0, 1, 0, 1);
      applyStimulus(1, 0, 1, 2);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(1, 0, 0, 2);

      // Saturation at floor 5
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1, 0, 1, DC);
         applyStimulus(1, 0, 0, 1);
      end
      checkOutput("dcnt5Sat", int'(dcnt5), 15);

      // Random traffic after a fresh reset
      applyStimulus(0, 0, 0, 1);
      for (int i = 0; i < 300; i++) begin
         int m, d;
         m = ($urandom_range(0, 9) < 6) ? $urandom_range(1, 2) : 0;
         if ($urandom_range(0, 40) == 0) m = 3;
         d = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         if ($urandom_range(0, 60) == 0) d = 3;
         applyStimulus(1, m, d, $urandom_range(1, 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
